// File: rtl/conv_window_serializer.sv
// Serializes one packed vector of N elements into an N-beat enable stream
// for the conv-unit accumulator, with downstream stall and gap-free chaining.
module conv_window_serializer #(
  parameter int DATAW = 8,
  parameter int N     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [N*DATAW-1:0]   in_data,
  output logic                 in_ready,
  input  logic                 out_stall,
  output logic                 out_enable,
  output logic [DATAW-1:0]     out_data,
  output logic                 out_last,
  output logic                 busy
);

  localparam int IW = $clog2(N) + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t             state;
  logic [IW-1:0]      idx;
  logic [N*DATAW-1:0] hold;

  logic streaming;
  logic at_last;
  logic accept;

  assign streaming  = (state == STREAM);
  assign at_last    = (idx == LAST_IDX);
  assign out_enable = streaming && !out_stall;
  assign out_last   = streaming && at_last;
  assign busy       = streaming;
  // Ready on the final unstalled beat lets the next vector chain without a bubble.
  assign in_ready   = !streaming || (at_last && !out_stall);
  assign accept     = in_valid && in_ready;

  // idx returns to 0 whenever the stream ends, so IDLE presents element 0.
  always_comb begin
    out_data = '0;
    for (int k = 0; k < N; k++) begin
      if (idx == IW'(k)) out_data = hold[k*DATAW +: DATAW];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      idx   <= '0;
      hold  <= '0;
    end else if (accept) begin
      hold  <= in_data;
      idx   <= '0;
      state <= STREAM;
    end else if (out_enable) begin
      if (at_last) begin
        state <= IDLE;
        idx   <= '0;
      end else begin
        idx   <= idx + IW'(1);
      end
    end
  end

endmodule

// File: tb/tb_conv_window_serializer.sv
// Self-checking bench for conv_window_serializer (N=4, DATAW=8): directed table,
// hand-written corner sequences and a randomized run against a queue-based model.
module tb_conv_window_serializer;

  localparam int DATAW = 8;
  localparam int N     = 4;

  logic             clk = 0;
  logic             rst_n;
  logic             in_valid;
  logic [31:0]      in_data;
  logic             in_ready;
  logic             out_stall;
  logic             out_enable;
  logic [7:0]       out_data;
  logic             out_last;
  logic             busy;

  int total = 0;
  int bad   = 0;

  conv_window_serializer #(.DATAW(DATAW), .N(N)) dut (
    .clk        (clk),
    .reset      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_stall  (out_stall),
    .out_enable (out_enable),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic        s;
    logic [31:0] d;
    logic        en;
    logic [7:0]  q;
    logic        last;
    logic        rdy;
    logic        bsy;
  } vec_t;

  vec_t tbl[21];

  function automatic vec_t mk(logic v, logic s, logic [31:0] d, logic en,
                              logic [7:0] q, logic last, logic rdy, logic bsy);
    vec_t r;
    r.v = v; r.s = s; r.d = d; r.en = en; r.q = q; r.last = last; r.rdy = rdy; r.bsy = bsy;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic en, input logic [7:0] q,
                         input logic last, input logic rdy, input logic bsy);
    chk({tag, ".enable"}, {31'd0, out_enable}, {31'd0, en});
    chk({tag, ".data"},   {24'd0, out_data},   {24'd0, q});
    chk({tag, ".last"},   {31'd0, out_last},   {31'd0, last});
    chk({tag, ".ready"},  {31'd0, in_ready},   {31'd0, rdy});
    chk({tag, ".busy"},   {31'd0, busy},       {31'd0, bsy});
  endtask

  task automatic apply(input logic v, input logic s, input logic [31:0] d);
    @(posedge clk);
    #1;
    in_valid  = v;
    out_stall = s;
    in_data   = d;
    @(negedge clk);
  endtask

  logic [7:0] pend[$];
  logic [7:0] hold0;
  logic [7:0] acc;
  logic [7:0] sums[2];
  int         nsum;

  initial begin
    rst_n     = 0;
    in_valid  = 1;
    in_data   = 32'h11223344;
    out_stall = 0;

    // reset held with in_valid high
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_all("rst", 0, 8'h00, 0, 1, 0);
    end
    @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    chk_all("rel", 0, 8'h00, 0, 1, 0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1 in_valid = 0;
      @(negedge clk);
      chk_all("first", 1, 8'h44 - 8'(k * 8'h11), k == 3, k == 3, 1);
    end
    apply(0, 0, 0);
    chk_all("first_idle", 0, 8'h44, 0, 1, 0);

    // directed table: single vector, stall mid-vector, stall on last beat
    tbl[0]  = mk(1, 0, 32'h04030201, 0, 8'h44, 0, 1, 0);
    tbl[1]  = mk(0, 0, 32'h0,        1, 8'h01, 0, 0, 1);
    tbl[2]  = mk(0, 0, 32'h0,        1, 8'h02, 0, 0, 1);
    tbl[3]  = mk(0, 0, 32'h0,        1, 8'h03, 0, 0, 1);
    tbl[4]  = mk(0, 0, 32'h0,        1, 8'h04, 1, 1, 1);
    tbl[5]  = mk(0, 0, 32'h0,        0, 8'h01, 0, 1, 0);
    tbl[6]  = mk(1, 0, 32'h04030201, 0, 8'h01, 0, 1, 0);
    tbl[7]  = mk(0, 0, 32'hDEADBEEF, 1, 8'h01, 0, 0, 1);
    tbl[8]  = mk(0, 1, 32'h0,        0, 8'h02, 0, 0, 1);
    tbl[9]  = mk(1, 1, 32'hCAFEF00D, 0, 8'h02, 0, 0, 1);
    tbl[10] = mk(0, 1, 32'h0,        0, 8'h02, 0, 0, 1);
    tbl[11] = mk(0, 0, 32'h0,        1, 8'h02, 0, 0, 1);
    tbl[12] = mk(0, 0, 32'h0,        1, 8'h03, 0, 0, 1);
    tbl[13] = mk(1, 1, 32'h08070605, 0, 8'h04, 1, 0, 1);
    tbl[14] = mk(1, 1, 32'h08070605, 0, 8'h04, 1, 0, 1);
    tbl[15] = mk(1, 0, 32'h08070605, 1, 8'h04, 1, 1, 1);
    tbl[16] = mk(0, 0, 32'h0,        1, 8'h05, 0, 0, 1);
    tbl[17] = mk(0, 0, 32'h0,        1, 8'h06, 0, 0, 1);
    tbl[18] = mk(0, 0, 32'h0,        1, 8'h07, 0, 0, 1);
    tbl[19] = mk(0, 0, 32'h0,        1, 8'h08, 1, 1, 1);
    tbl[20] = mk(0, 0, 32'h0,        0, 8'h05, 0, 1, 0);
    for (int i = 0; i < 21; i++) begin
      apply(tbl[i].v, tbl[i].s, tbl[i].d);
      chk_all($sformatf("tbl%0d", i), tbl[i].en, tbl[i].q, tbl[i].last, tbl[i].rdy, tbl[i].bsy);
    end

    // back-to-back vectors with an accumulator on the stream
    apply(1, 0, 32'h04030201);
    chk_all("b2b_acc", 0, 8'h05, 0, 1, 0);
    acc  = 0;
    nsum = 0;
    for (int i = 1; i <= 8; i++) begin
      apply(i <= 4, 0, 32'h08070605);
      chk_all($sformatf("b2b%0d", i), 1, 8'(i), (i == 4) || (i == 8), (i == 4) || (i == 8), 1);
      if (out_enable) acc = acc + out_data;
      if (out_enable && out_last && nsum < 2) begin
        sums[nsum] = acc;
        nsum++;
        acc = 0;
      end
    end
    chk("b2b.nsum", 32'(nsum), 32'd2);
    if (nsum == 2) begin
      chk("b2b.sum0", {24'd0, sums[0]}, 32'h0A);
      chk("b2b.sum1", {24'd0, sums[1]}, 32'h1A);
    end
    apply(0, 0, 0);
    chk_all("b2b_idle", 0, 8'h05, 0, 1, 0);

    // asynchronous reset mid-stream
    apply(1, 0, 32'h04030201);
    apply(0, 0, 0);
    chk_all("mid01", 1, 8'h01, 0, 0, 1);
    apply(0, 0, 0);
    chk_all("mid02", 1, 8'h02, 0, 0, 1);
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk_all("mid_rst", 0, 8'h00, 0, 1, 0);
    @(posedge clk);
    #1;
    rst_n    = 1;
    in_valid = 1;
    in_data  = 32'h0D0C0B0A;
    @(negedge clk);
    chk_all("mid_rel", 0, 8'h00, 0, 1, 0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1 in_valid = 0;
      @(negedge clk);
      chk_all($sformatf("mid_new%0d", k), 1, 8'h0A + 8'(k), k == 3, k == 3, 1);
    end
    apply(0, 0, 0);
    chk_all("mid_idle", 0, 8'h0A, 0, 1, 0);

    // randomized traffic against a queue model of the element stream
    hold0 = 8'h0A;
    pend.delete();
    for (int c = 0; c < 400; c++) begin
      logic        v, s, eb, een, elast, erdy;
      logic [7:0]  eq;
      logic [31:0] d;
      v = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 3) == 0);
      d = $urandom;
      apply(v, s, d);
      eb    = (pend.size() != 0);
      een   = eb && !s;
      eq    = eb ? pend[0] : hold0;
      elast = eb && (pend.size() == 1);
      erdy  = !eb || ((pend.size() == 1) && !s);
      chk_all($sformatf("rnd%0d", c), een, eq, elast, erdy, eb);
      if (een) void'(pend.pop_front());
      if (v && erdy) begin
        pend.delete();
        for (int k = 0; k < N; k++) pend.push_back(d[k*8 +: 8]);
        hold0 = d[7:0];
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
